// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_mem_ctrl shared definitions
// mem_op encodings, FSM states, access checks
package lsu_mem_ctrl_pkg;

  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b100;
  localparam logic [2:0] MEM_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  // Illegal format, misalignment or conflicting enables
  function automatic logic lsu_access_err(
    input logic       rd,
    input logic       wr,
    input logic [2:0] op,
    input logic [1:0] off
  );
    logic bad_op;
    logic mis;
    bad_op = rd ? (op == 3'b011 || op[2:1] == 2'b11)
                : (op[1:0] == 2'b11);
    mis = (op[1:0] == 2'b01 && off[0]) ||
          (op[1:0] == 2'b10 && off != 2'b00);
    return (rd & wr) | ((rd | wr) & (bad_op | mis));
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// lsu_align: store lane/mask build and
// load lane extract with sign/zero extend
import lsu_mem_ctrl_pkg::*;

module lsu_align (
  input  logic [2:0]  i_st_op,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_st_data,
  output logic [3:0]  o_st_mask,
  input  logic [2:0]  i_ld_op,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_byte;
  logic [31:0] w_half;
  logic        w_sext;

  assign w_byte = i_ld_word >> {i_ld_off, 3'b000};
  assign w_half = i_ld_word >> {i_ld_off[1], 4'b0000};
  assign w_sext = ~i_ld_op[2];

  // Replicate store data across lanes and pick byte enables
  always_comb begin
    o_st_data = i_st_data;
    o_st_mask = 4'b1111;
    unique case (i_st_op[1:0])
      2'b00: begin
        o_st_data = {4{i_st_data[7:0]}};
        o_st_mask = 4'b0001 << i_st_off;
      end
      2'b01: begin
        o_st_data = {2{i_st_data[15:0]}};
        o_st_mask = 4'b0011 << {i_st_off[1], 1'b0};
      end
      default: begin
        o_st_data = i_st_data;
        o_st_mask = 4'b1111;
      end
    endcase
  end

  // Extract the addressed lane and extend to 32 bits
  always_comb begin
    o_ld_data = i_ld_word;
    unique case (i_ld_op[1:0])
      2'b00:
        o_ld_data = {{24{w_sext & w_byte[7]}}, w_byte[7:0]};
      2'b01:
        o_ld_data = {{16{w_sext & w_half[15]}}, w_half[15:0]};
      default:
        o_ld_data = i_ld_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit between EXU and WBU
// one access in flight, valid/ready on every side
import lsu_mem_ctrl_pkg::*;

module lsu_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_mem_rd_en,
  input  logic              i_mem_wr_en,
  input  logic [2:0]        i_mem_op,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_bus_req_valid,
  input  logic              i_bus_req_ready,
  output logic              o_bus_wen,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  output logic [3:0]        o_bus_wmask,
  input  logic              i_bus_resp_valid,
  input  logic [DATA_W-1:0] i_bus_rdata,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_rdata,
  output logic              o_out_err
);

  lsu_state_e        r_state;
  lsu_state_e        w_next;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wmask;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_err;
  logic              w_go_req;
  logic              w_accept;
  logic [31:0]       w_st_data;
  logic [3:0]        w_st_mask;
  logic [31:0]       w_ld_data;

  assign w_err    = lsu_access_err(i_mem_rd_en, i_mem_wr_en,
                                   i_mem_op, i_addr[1:0]);
  assign w_go_req = (i_mem_rd_en | i_mem_wr_en) & ~w_err;
  assign w_accept = (r_state == S_IDLE) & i_in_valid;

  lsu_align u_align (
    .i_st_op   (i_mem_op),
    .i_st_off  (i_addr[1:0]),
    .i_st_data (i_wdata),
    .o_st_data (w_st_data),
    .o_st_mask (w_st_mask),
    .i_ld_op   (r_op),
    .i_ld_off  (r_addr[1:0]),
    .i_ld_word (i_bus_rdata),
    .o_ld_data (w_ld_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and handshake outputs
  always_comb begin
    w_next          = r_state;
    o_in_ready      = 1'b0;
    o_bus_req_valid = 1'b0;
    o_out_valid     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid)
          w_next = w_go_req ? S_REQ : S_DONE;
      end
      S_REQ: begin
        o_bus_req_valid = 1'b1;
        if (i_bus_req_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_bus_resp_valid) w_next = S_DONE;
      end
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the access on accept, the result on response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= 3'b000;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= 4'b0000;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_err   <= w_err;
      r_rdata <= '0;
      r_op    <= i_mem_op;
      if (w_go_req) begin
        r_addr  <= i_addr;
        r_wen   <= i_mem_wr_en;
        r_wdata <= w_st_data;
        r_wmask <= i_mem_wr_en ? w_st_mask : 4'b0000;
      end
    end else if (r_state == S_WAIT && i_bus_resp_valid) begin
      r_rdata <= r_wen ? '0 : w_ld_data;
    end
  end

  assign o_bus_wen   = r_wen;
  assign o_bus_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign o_bus_wdata = r_wdata;
  assign o_bus_wmask = r_wmask;
  assign o_out_rdata = r_rdata;
  assign o_out_err   = r_err;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: random + directed accesses
// against a byte-level reference model
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic        i_mem_rd_en = 1'b0;
  logic        i_mem_wr_en = 1'b0;
  logic [2:0]  i_mem_op = 3'b000;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        o_bus_req_valid;
  logic        i_bus_req_ready = 1'b0;
  logic        o_bus_wen;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_wmask;
  logic        i_bus_resp_valid = 1'b0;
  logic [31:0] i_bus_rdata = '0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic [31:0] o_out_rdata;
  logic        o_out_err;

  lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_in_valid       (i_in_valid),
    .o_in_ready       (o_in_ready),
    .i_mem_rd_en      (i_mem_rd_en),
    .i_mem_wr_en      (i_mem_wr_en),
    .i_mem_op         (i_mem_op),
    .i_addr           (i_addr),
    .i_wdata          (i_wdata),
    .o_bus_req_valid  (o_bus_req_valid),
    .i_bus_req_ready  (i_bus_req_ready),
    .o_bus_wen        (o_bus_wen),
    .o_bus_addr       (o_bus_addr),
    .o_bus_wdata      (o_bus_wdata),
    .o_bus_wmask      (o_bus_wmask),
    .i_bus_resp_valid (i_bus_resp_valid),
    .i_bus_rdata      (i_bus_rdata),
    .o_out_valid      (o_out_valid),
    .i_out_ready      (i_out_ready),
    .o_out_rdata      (o_out_rdata),
    .o_out_err        (o_out_err)
  );

  always #5 clk = ~clk;

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_WAIT = 2;
  localparam int P_DONE = 3;
  localparam int P_RST  = 4;

  int vectors = 0;
  int errors  = 0;
  int phase   = P_RST;

  logic        e_wen;
  logic [31:0] e_addr;
  logic [31:0] e_wdata;
  logic [3:0]  e_mask;
  logic [31:0] e_rdata;
  logic        e_err;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] op);
    return 1 << op[1:0];
  endfunction

  function automatic logic m_err(input logic rd, input logic wr,
                                 input logic [2:0] op,
                                 input logic [31:0] a);
    if (rd && wr) return 1'b1;
    if (!rd && !wr) return 1'b0;
    if (op[1:0] == 2'b11) return 1'b1;
    if (rd && op[2] && op[1:0] == 2'b10) return 1'b1;
    return (a % nbytes(op)) != 0;
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] op,
                                        input logic [31:0] a);
    logic [3:0] m;
    int off;
    off = int'(a % 4);
    m = '0;
    for (int i = 0; i < 4; i++)
      m[i] = (i >= off) && (i < off + nbytes(op));
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op,
                                          input logic [31:0] d);
    logic [31:0] v;
    for (int i = 0; i < 4; i++)
      v[8*i +: 8] = d[8*(i % nbytes(op)) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] v;
    int n;
    int off;
    n = nbytes(op);
    off = int'(a % 4);
    v = '0;
    for (int k = 0; k < n; k++)
      v[8*k +: 8] = w[8*(off+k) +: 8];
    if (!op[2] && n < 4 && v[8*n-1])
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  // Per-cycle comparison of DUT outputs against the expected phase
  always @(negedge clk) begin
    chk("in_ready", 32'(o_in_ready),
        32'(phase == P_IDLE || phase == P_RST));
    chk("req_valid", 32'(o_bus_req_valid), 32'(phase == P_REQ));
    chk("out_valid", 32'(o_out_valid), 32'(phase == P_DONE));
    if (phase == P_REQ) begin
      chk("bus_addr", o_bus_addr, e_addr);
      chk("bus_wen", 32'(o_bus_wen), 32'(e_wen));
      chk("bus_wmask", 32'(o_bus_wmask), 32'(e_mask));
      if (e_wen) chk("bus_wdata", o_bus_wdata, e_wdata);
    end
    if (phase == P_DONE) begin
      chk("out_rdata", o_out_rdata, e_rdata);
      chk("out_err", 32'(o_out_err), 32'(e_err));
    end
    if (phase == P_RST) begin
      chk("rst_wen", 32'(o_bus_wen), 0);
      chk("rst_addr", o_bus_addr, 0);
      chk("rst_wdata", o_bus_wdata, 0);
      chk("rst_wmask", 32'(o_bus_wmask), 0);
      chk("rst_rdata", o_out_rdata, 0);
      chk("rst_err", 32'(o_out_err), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and walk it through with given stalls
  task automatic run(input logic rd, input logic wr,
                     input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rw,
                     input int dreq, input int dresp, input int dout);
    logic err;
    err = m_err(rd, wr, op, a);
    e_err   = err;
    e_wen   = wr;
    e_addr  = {a[31:2], 2'b00};
    e_mask  = wr ? m_mask(op, a) : 4'b0000;
    e_wdata = m_wdata(op, wd);
    e_rdata = (rd && !wr && !err) ? m_load(op, a, rw) : 32'h0;
    i_in_valid  = 1'b1;
    i_mem_rd_en = rd;
    i_mem_wr_en = wr;
    i_mem_op    = op;
    i_addr      = a;
    i_wdata     = wd;
    tick();
    i_in_valid  = 1'b0;
    i_mem_rd_en = 1'($urandom);
    i_mem_wr_en = 1'($urandom);
    i_mem_op    = 3'($urandom);
    i_addr      = $urandom;
    i_wdata     = $urandom;
    if ((rd || wr) && !err) begin
      phase = P_REQ;
      i_bus_req_ready = 1'b0;
      repeat (dreq) tick();
      i_bus_req_ready = 1'b1;
      tick();
      i_bus_req_ready = 1'b0;
      phase = P_WAIT;
      i_bus_rdata = $urandom;
      repeat (dresp) tick();
      i_bus_resp_valid = 1'b1;
      i_bus_rdata = rw;
      tick();
      i_bus_resp_valid = 1'b0;
    end
    phase = P_DONE;
    i_out_ready = 1'b0;
    i_bus_resp_valid = 1'b1;
    i_bus_rdata = $urandom;
    repeat (dout) tick();
    i_bus_resp_valid = 1'b0;
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    phase = P_IDLE;
  endtask

  initial begin
    logic [2:0] legal [5];
    legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010;
    legal[3] = 3'b100; legal[4] = 3'b101;

    chk("pin_lb", m_load(3'b000, 32'h80000003, 32'h80123456),
        32'hFFFFFF80);
    chk("pin_lbu", m_load(3'b100, 32'h80000003, 32'h80123456),
        32'h00000080);
    chk("pin_sh_mask", 32'(m_mask(3'b001, 32'h80000002)), 32'hC);
    chk("pin_sh_data", m_wdata(3'b001, 32'h0000ABCD), 32'hABCDABCD);
    chk("pin_lw_mis", 32'(m_err(1, 0, 3'b010, 32'h80000001)), 1);

    phase = P_RST;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    phase = P_IDLE;
    tick();

    run(1, 0, 3'b010, 32'h80000004, 0, 32'hDEADBEEF, 0, 0, 0);
    run(1, 0, 3'b000, 32'h80000003, 0, 32'h80123456, 0, 0, 0);
    run(1, 0, 3'b100, 32'h80000003, 0, 32'h80123456, 0, 1, 0);
    run(0, 1, 3'b001, 32'h80000002, 32'h0000ABCD, 0, 3, 0, 0);
    run(1, 0, 3'b010, 32'h80000001, 0, 0, 0, 0, 0);
    run(1, 0, 3'b101, 32'h80000002, 0, 32'h8001FFFF, 1, 2, 2);
    run(0, 0, 3'b010, 32'h80000000, 0, 0, 0, 0, 1);
    run(1, 1, 3'b010, 32'h80000000, 0, 0, 0, 0, 0);

    // Reset while waiting for the read response
    i_in_valid = 1'b1;
    i_mem_rd_en = 1'b1;
    i_mem_wr_en = 1'b0;
    i_mem_op = 3'b010;
    i_addr = 32'h80000010;
    e_addr = 32'h80000010;
    e_wen = 1'b0;
    e_mask = 4'b0000;
    tick();
    i_in_valid = 1'b0;
    phase = P_REQ;
    i_bus_req_ready = 1'b1;
    tick();
    i_bus_req_ready = 1'b0;
    phase = P_WAIT;
    tick();
    rst_n = 1'b0;
    phase = P_RST;
    #1;
    chk("async_rst_addr", o_bus_addr, 0);
    chk("async_rst_ready", 32'(o_in_ready), 1);
    tick();
    rst_n = 1'b1;
    phase = P_IDLE;
    i_bus_resp_valid = 1'b1;
    i_bus_rdata = 32'h12345678;
    tick();
    i_bus_resp_valid = 1'b0;
    chk("late_resp_rdata", o_out_rdata, 0);
    run(1, 0, 3'b010, 32'h80000020, 0, 32'hCAFEF00D, 0, 0, 0);

    for (int t = 0; t < 300; t++) begin
      int r;
      logic rd, wr;
      logic [2:0] op;
      logic [31:0] a;
      r = $urandom_range(0, 99);
      rd = (r < 45) || (r >= 95);
      wr = (r >= 45 && r < 85) || (r >= 95);
      op = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 4)]
                                       : 3'($urandom);
      a = $urandom;
      if ($urandom_range(0, 2) != 0)
        a = a & ~((32'd1 << op[1:0]) - 32'd1);
      run(rd, wr, op, a, $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 2));
      repeat ($urandom_range(0, 1)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store execution unit that consumes the memory control fields (`mem_rd_en`, `mem_wr_en`, `mem_op`) produced by the control signal generator, together with the ALU address and rs2 data. It drives a word-addressed data-memory bus with valid/ready requests and byte-lane write masks. For loads, it aligns and sign- or zero-extends the returned word. It sits between EXU and WBU in the NPC core and applies back-pressure to the core through a valid/ready pair on each side.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; fixed at 32 (4 byte lanes).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  EXU presents an instruction.
- `in_ready`  out  1  unit can accept an instruction.
- `mem_rd_en`, `mem_wr_en`  in  1 each  load / store request.
- `mem_op`  in  3  access format:
  - 000: byte, signed.
  - 001: half, signed.
  - 010: word.
  - 100: byte, unsigned.
  - 101: half, unsigned.
  - Stores ignore bit 2.
- `addr`  in  ADDR_W  byte address from ALU.
- `wdata`  in  32  store data (rs2).
- `bus_req_valid`  out  1  bus request.
- `bus_req_ready`  in  1  bus accepts the request.
- `bus_wen`  out  1  1 = write.
- `bus_addr`  out  ADDR_W  word-aligned address ({addr[31:2],2'b00}).
- `bus_wdata`  out  32  lane-shifted store data.
- `bus_wmask`  out  4  byte-lane enables; 0000 for reads.
- `bus_resp_valid`  in  1  bus response (read data or write ack).
- `bus_rdata`  in  32  read word.
- `out_valid`  out  1  result ready for WBU.
- `out_ready`  in  1  WBU consumes the result.
- `out_rdata`  out  32  extended load data; 0 for stores and non-memory instructions.
- `out_err`  out  1  misaligned access, illegal `mem_op`, or both enables set.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE
  - `in_ready`=1.
  - On `in_valid`, the unit latches `mem_rd_en`, `mem_wr_en`, `mem_op`, `addr` and `wdata`.
  - Goes to DONE if any of the following holds:
    - no memory op;
    - error: half with addr[0]=1, word with addr[1:0]≠0, `mem_op` ∈ {011,110,111} for loads, `mem_op[1:0]`=11 for stores, or both enables set.
  - Otherwise goes to REQ.
- REQ
  - `bus_req_valid`=1.
  - `bus_addr`, `bus_wen`, `bus_wdata` and `bus_wmask` are held stable from registers.
  - On `bus_req_ready`, goes to WAIT.
- WAIT
  - On `bus_resp_valid`, latches `out_rdata` and goes to DONE.
  - For loads, `out_rdata` is the extracted lane, extended.
  - For stores, `out_rdata` is 0.
- DONE
  - `out_valid`=1.
  - On `out_ready`, goes to IDLE.
- Store lanes:
  - SB: `wdata[7:0]` replicated to all lanes; mask = 0001 << addr[1:0].
  - SH: `wdata[15:0]` replicated to both halves; mask = 0011 << {addr[1],1'b0}.
  - SW: mask = 1111.
- Load extract:
  - byte = `bus_rdata` >> (8·addr[1:0]).
  - half = `bus_rdata` >> (16·addr[1]).
  - Sign extension uses bit 7 or bit 15 when `mem_op[2]`=0; otherwise zero extension.
- Errored instructions never raise `bus_req_valid`, and they report `out_rdata`=0.
- `bus_resp_valid` outside WAIT is ignored.

## Timing
- Reset values:
  - state = IDLE, `in_ready`=1.
  - `bus_req_valid`=0, `bus_wen`=0, `bus_addr`=0, `bus_wdata`=0, `bus_wmask`=0.
  - `out_valid`=0, `out_rdata`=0, `out_err`=0.
- Minimum memory latency, with accept at edge 0:
  - `bus_req_valid` is high in cycle 1.
  - If `bus_req_ready`=1 in cycle 1 and `bus_resp_valid`=1 in cycle 2, `out_valid` is high in cycle 3.
- Non-memory or errored instruction: `out_valid` is high the cycle after acceptance.
- Only one instruction is in flight; `in_ready`=0 outside IDLE.
- A response arriving in the same cycle as the WAIT entry is not possible, because WAIT is entered on the edge.
- Handshakes:
  - Outputs hold while the corresponding ready is low.
  - `bus_req_valid` never drops before `bus_req_ready`.
- Reset asserted mid-transaction:
  - The unit returns to IDLE immediately, asynchronously.
  - All outputs take their reset values.
  - A late `bus_resp_valid` after reset is ignored.

## Structure
- Shared package holds:
  - `mem_op` encodings (MEM_LB=3'b000, MEM_LH=3'b001, MEM_LW=3'b010, MEM_LBU=3'b100, MEM_LHU=3'b101);
  - the FSM state enum.
- The control signal generator uses the same encodings.
- One natural sub-module, `lsu_align`: purely combinational store lane/mask generation and load extract/extend, reusable by a later cache.

## Test plan
- LW, addr=0x80000004, `bus_rdata`=0xDEADBEEF, one-cycle bus → `bus_addr`=0x80000004, `bus_wmask`=0000, `out_rdata`=0xDEADBEEF, `out_valid` at cycle 3.
- LB at addr 0x80000003 with `bus_rdata`=0x80123456 → `out_rdata`=0xFFFFFF80; the same access as LBU → 0x00000080.
- SH, addr=0x80000002, `wdata`=0x0000ABCD → `bus_wen`=1, `bus_wmask`=1100, `bus_wdata`=0xABCDABCD; on the ack, `out_rdata`=0.
- LW at addr 0x80000001 → no `bus_req_valid`; `out_valid`=1 and `out_err`=1 the next cycle.
- Back-pressure:
  - `bus_req_ready` held low for 3 cycles → request fields stay stable.
  - `out_ready` held low for 2 cycles → `out_valid` and `out_rdata` stay stable and `in_ready`=0.
- `rst_n` pulsed low during WAIT → all outputs return to their reset values; the subsequent `bus_resp_valid` is ignored; a new LW completes normally.
